svf_ctrl: RTL and testbench

Register-programmed controller for the 8-bit state variable filter. It generates the filter's sample strobe from the system clock and holds the cutoff and damping coefficients. Cutoff changes are slewed toward the programmed target one step per sample to avoid zipper noise. It also mixes the enabled HP/BP/LP outputs (or the bypassed input), applies a 4-bit master volume, and registers the final 8-bit audio sample.

---
 rtl/svf_ctrl.sv | 152 +++++++++++++++
 tb/tb_svf_ctrl.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/svf_ctrl.sv
// Control block for the 8-bit state variable filter: sample-rate divider, coefficient registers
// with cutoff slewing, and the output mixer / master volume stage.
module svf_ctrl #(
  parameter int unsigned CLK_DIV   = 24,
  parameter int unsigned SLEW_STEP = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic [1:0]  wr_addr,
  input  logic [7:0]  wr_data,
  input  logic [7:0]  audio_in,
  input  logic [7:0]  hp_in,
  input  logic [7:0]  bp_in,
  input  logic [7:0]  lp_in,
  output logic        sample_valid,
  output logic [10:0] alpha1,
  output logic [1:0]  alpha2,
  output logic        slewing,
  output logic [7:0]  audio_out
);

  localparam logic [7:0]  DivLast = 8'(CLK_DIV - 1);
  localparam logic [10:0] Step    = 11'(SLEW_STEP);

  localparam logic [1:0] AddrFcLo   = 2'd0;
  localparam logic [1:0] AddrFcHi   = 2'd1;
  localparam logic [1:0] AddrRes    = 2'd2;
  localparam logic [1:0] AddrModeVol = 2'd3;

  logic [7:0]  cnt_q, cnt_d;
  logic [10:0] fc_target_q, fc_target_d;
  logic [10:0] alpha1_q, alpha1_d;
  logic [1:0]  alpha2_q, alpha2_d;
  logic        filt_en_q, filt_en_d;
  logic [2:0]  mode_q, mode_d;  // {hp_en, bp_en, lp_en}
  logic [3:0]  vol_q, vol_d;
  logic [7:0]  audio_out_q, audio_out_d;

  logic [10:0]        diff_up, diff_dn;
  logic signed [9:0]  mix;
  logic signed [14:0] mix_x, vol_x, prod;
  logic signed [10:0] prod_sh;
  logic [7:0]         sat;

  // Divider
  always_comb begin
    cnt_d = (cnt_q == DivLast) ? 8'd0 : cnt_q + 8'd1;
  end

  assign sample_valid = (cnt_q == DivLast);

  // Register file; the datapath below always sees the pre-write values on a strobe edge.
  always_comb begin
    fc_target_d = fc_target_q;
    alpha2_d    = alpha2_q;
    filt_en_d   = filt_en_q;
    mode_d      = mode_q;
    vol_d       = vol_q;
    if (wr_en) begin
      unique case (wr_addr)
        AddrFcLo:    fc_target_d[2:0]  = wr_data[2:0];
        AddrFcHi:    fc_target_d[10:3] = wr_data;
        AddrRes: begin
          alpha2_d  = wr_data[7:6];
          filt_en_d = wr_data[0];
        end
        AddrModeVol: begin
          mode_d = wr_data[6:4];
          vol_d  = wr_data[3:0];
        end
        default: ;
      endcase
    end
  end

  // Cutoff slew: saturating step toward the target, never overshooting or wrapping.
  assign diff_up = fc_target_q - alpha1_q;
  assign diff_dn = alpha1_q - fc_target_q;

  always_comb begin
    alpha1_d = alpha1_q;
    if (sample_valid) begin
      if (SLEW_STEP == 0) begin
        alpha1_d = fc_target_q;
      end else if (fc_target_q >= alpha1_q) begin
        alpha1_d = (diff_up <= Step) ? fc_target_q : alpha1_q + Step;
      end else begin
        alpha1_d = (diff_dn <= Step) ? fc_target_q : alpha1_q - Step;
      end
    end
  end

  // Output mixer and volume
  always_comb begin
    mix = '0;
    if (filt_en_q) begin
      if (mode_q[2]) mix = mix + {{2{hp_in[7]}}, hp_in};
      if (mode_q[1]) mix = mix + {{2{bp_in[7]}}, bp_in};
      if (mode_q[0]) mix = mix + {{2{lp_in[7]}}, lp_in};
    end else begin
      mix = {{2{audio_in[7]}}, audio_in};
    end
  end

  assign mix_x   = {{5{mix[9]}}, mix};
  assign vol_x   = {11'd0, vol_q};
  assign prod    = mix_x * vol_x;
  assign prod_sh = prod[14:4];

  always_comb begin
    if (prod_sh > 11'sd127) begin
      sat = 8'h7f;
    end else if (prod_sh < -11'sd128) begin
      sat = 8'h80;
    end else begin
      sat = prod_sh[7:0];
    end
  end

  always_comb begin
    audio_out_d = sample_valid ? sat : audio_out_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q       <= '0;
      fc_target_q <= '0;
      alpha1_q    <= '0;
      alpha2_q    <= '0;
      filt_en_q   <= 1'b0;
      mode_q      <= '0;
      vol_q       <= '0;
      audio_out_q <= '0;
    end else begin
      cnt_q       <= cnt_d;
      fc_target_q <= fc_target_d;
      alpha1_q    <= alpha1_d;
      alpha2_q    <= alpha2_d;
      filt_en_q   <= filt_en_d;
      mode_q      <= mode_d;
      vol_q       <= vol_d;
      audio_out_q <= audio_out_d;
    end
  end

  assign alpha1    = alpha1_q;
  assign alpha2    = alpha2_q;
  assign slewing   = (alpha1_q != fc_target_q);
  assign audio_out = audio_out_q;

endmodule

// File: tb/tb_svf_ctrl.sv
// Bench for svf_ctrl: directed scenarios plus random traffic, checked every cycle against an
// arithmetic reference model of the register map, divider, slew and mixer.
module tb_svf_ctrl;

  localparam int Div  = 24;
  localparam int Slew = 8;

  logic        clk;
  logic        rst;
  logic        wr_en;
  logic [1:0]  wr_addr;
  logic [7:0]  wr_data;
  logic signed [7:0] audio_in, hp_in, bp_in, lp_in;
  logic        sample_valid;
  logic [10:0] alpha1;
  logic [1:0]  alpha2;
  logic        slewing;
  logic [7:0]  audio_out;

  svf_ctrl #(
    .CLK_DIV  (Div),
    .SLEW_STEP(Slew)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .audio_in    (audio_in),
    .hp_in       (hp_in),
    .bp_in       (bp_in),
    .lp_in       (lp_in),
    .sample_valid(sample_valid),
    .alpha1      (alpha1),
    .alpha2      (alpha2),
    .slewing     (slewing),
    .audio_out   (audio_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model state
  int m_cyc;
  int m_fc, m_a1, m_a2, m_fen, m_hp, m_bp, m_lp, m_vol, m_out;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int clamp8(input int v);
    if (v > 127) return 127;
    if (v < -128) return -128;
    return v;
  endfunction

  function automatic int floor_div16(input int p);
    if (p >= 0) return p / 16;
    return -((-p + 15) / 16);
  endfunction

  task automatic check_all();
    chk("sample_valid", int'(sample_valid), (m_cyc % Div == Div - 1) ? 1 : 0);
    chk("alpha1", int'(alpha1), m_a1);
    chk("alpha2", int'(alpha2), m_a2);
    chk("slewing", int'(slewing), (m_a1 != m_fc) ? 1 : 0);
    chk("audio_out", int'($signed(audio_out)), m_out);
  endtask

  // One clock: predict from pre-edge inputs and state, clock, then compare.
  task automatic step();
    int mix;
    int d;
    bit strobe;
    strobe = (m_cyc % Div) == Div - 1;
    if (rst) begin
      m_cyc = 0; m_fc = 0; m_a1 = 0; m_a2 = 0; m_fen = 0;
      m_hp = 0; m_bp = 0; m_lp = 0; m_vol = 0; m_out = 0;
    end else begin
      if (strobe) begin
        if (m_fc - m_a1 <= Slew && m_a1 - m_fc <= Slew) m_a1 = m_fc;
        else if (m_fc > m_a1) m_a1 = m_a1 + Slew;
        else m_a1 = m_a1 - Slew;
        if (m_fen != 0) begin
          mix = 0;
          if (m_hp != 0) mix += int'(hp_in);
          if (m_bp != 0) mix += int'(bp_in);
          if (m_lp != 0) mix += int'(lp_in);
        end else begin
          mix = int'(audio_in);
        end
        m_out = clamp8(floor_div16(mix * m_vol));
      end
      if (wr_en) begin
        d = int'(wr_data);
        case (wr_addr)
          2'd0: m_fc = (m_fc / 8) * 8 + d % 8;
          2'd1: m_fc = d * 8 + m_fc % 8;
          2'd2: begin m_a2 = d / 64; m_fen = d % 2; end
          default: begin
            m_hp = (d / 64) % 2; m_bp = (d / 32) % 2; m_lp = (d / 16) % 2; m_vol = d % 16;
          end
        endcase
      end
      m_cyc++;
    end
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    step();
    wr_en = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    run(3);
    rst = 1'b0;
  endtask

  task automatic to_strobe_cycle();
    while (m_cyc % Div != Div - 1) step();
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    audio_in = '0; hp_in = '0; bp_in = '0; lp_in = '0;
    m_cyc = 0;
    do_reset();

    // Idle after reset: strobes at 23, 47, 71, 95, outputs stay zero
    for (int i = 0; i < 100; i++) begin
      audio_in = 8'($urandom); hp_in = 8'($urandom); lp_in = 8'($urandom);
      step();
      if (i == 22 || i == 46 || i == 70 || i == 94) chk("first_pulses", int'(sample_valid), 1);
    end

    // Slew up to 256, then down to 8, then 9 -> 5
    do_reset();
    wr(2'd1, 8'h20);
    run(32 * Div + 2);
    chk("alpha1_up_final", int'(alpha1), 256);
    chk("slew_up_done", int'(slewing), 0);
    wr(2'd1, 8'h01);
    run(31 * Div + 2);
    chk("alpha1_down_final", int'(alpha1), 8);
    wr(2'd0, 8'h01);
    run(Div + 1);
    chk("alpha1_nine", int'(alpha1), 9);
    wr(2'd1, 8'h00);
    wr(2'd0, 8'h05);
    run(Div + 1);
    chk("alpha1_snap5", int'(alpha1), 5);

    // Filtered mix HP+LP, full volume, saturation both ways
    wr(2'd2, 8'hC1);
    wr(2'd3, 8'h5F);
    hp_in = 8'sd100; lp_in = 8'sd100; bp_in = 8'sd77;
    run(2 * Div);
    chk("sat_pos", int'($signed(audio_out)), 127);
    hp_in = -8'sd100; lp_in = -8'sd100;
    run(2 * Div);
    chk("sat_neg", int'($signed(audio_out)), -128);

    // Bypass with volume 8 then 0
    wr(2'd2, 8'h00);
    wr(2'd3, 8'h08);
    audio_in = -8'sd64;
    run(2 * Div);
    chk("bypass_vol8", int'($signed(audio_out)), -32);
    wr(2'd3, 8'h00);
    run(2 * Div);
    chk("bypass_vol0", int'($signed(audio_out)), 0);

    // Target change written on the strobe cycle
    do_reset();
    wr(2'd1, 8'h20);
    run(3 * Div);
    to_strobe_cycle();
    wr(2'd1, 8'h02);
    chk("strobe_wr_old_target", int'(alpha1), 32);
    run(Div);
    chk("strobe_wr_new_target", int'(alpha1), 24);
    run(2 * Div);

    // Writes to mode/volume on a strobe cycle use the old settings
    wr(2'd3, 8'h7A);
    to_strobe_cycle();
    wr(2'd3, 8'h23);
    run(Div);

    // Reset mid-slew
    wr(2'd1, 8'h80);
    run(5 * Div);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst_alpha1", int'(alpha1), 0);
    chk("rst_slewing", int'(slewing), 0);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      audio_in = 8'($urandom); hp_in = 8'($urandom); bp_in = 8'($urandom);
      lp_in = 8'($urandom);
      if ($urandom_range(5, 0) == 0) begin
        wr_en = 1'b1; wr_addr = 2'($urandom); wr_data = 8'($urandom);
      end
      rst = ($urandom_range(999, 0) == 0);
      step();
      wr_en = 1'b0;
      rst = 1'b0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
